pdp11_trace_buffer: RTL

Synthesizable execution-trace capture block for the pdp11 core. It records one entry per qualified cycle into a circular buffer: pc, psw, istate, an instruction-start flag and a cycle stamp. Capture runs from arm until a pc-match trigger plus a post-trigger window, or until the CPU halts. In hardware and in long simulations it replaces per-cycle console printing, and the host reads the captured history back afterwards.

---
 rtl/pdp11_trace_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pdp11_trace_buffer.sv
// Execution-trace capture for the pdp11 core: circular buffer of
// {fetch, istate, psw, pc, stamp} with arm / pc-trigger / halt control.
module pdp11_trace_buffer #(
    parameter int DEPTH        = 64,
    parameter int ISTATE_W     = 4,
    parameter int HALT_ISTATE  = 0,
    parameter int FETCH_ISTATE = 1,
    parameter int POST_TRIG    = 16,
    localparam int AW          = $clog2(DEPTH),
    localparam int EW          = 49 + ISTATE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                sample,
    input  logic [15:0]         pc,
    input  logic [15:0]         psw,
    input  logic [ISTATE_W-1:0] istate,
    input  logic                trig_en,
    input  logic [15:0]         trig_pc,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_en,
    output logic [EW-1:0]       rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                triggered,
    output logic                halted,
    output logic [AW:0]         count,
    output logic [31:0]         cycle_count
);

    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pdp11_trace_buffer: DEPTH must be a power of two in 4..4096");
    end
    if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post
        $error("pdp11_trace_buffer: POST_TRIG must be below DEPTH");
    end

    localparam logic [ISTATE_W-1:0] HALT_V  = ISTATE_W'(HALT_ISTATE);
    localparam logic [ISTATE_W-1:0] FETCH_V = ISTATE_W'(FETCH_ISTATE);
    localparam logic [AW-1:0]       POST_V  = AW'(POST_TRIG);
    localparam logic [AW:0]         FULL    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] post_q, post_d;
    logic          trig_q, trig_d;
    logic          halt_q, halt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_zero_q, rd_zero_d;

    logic          cap;
    logic          hit;
    logic          hlt;
    logic          we;
    logic [EW-1:0] wdata;
    logic [AW-1:0] phys;
    logic [EW-1:0] ram_q;
    logic [EW-1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        post_d     = post_q;
        trig_d     = trig_q;
        halt_d     = halt_q;
        we         = 1'b0;
        cyc_d      = cyc_q + 32'd1;
        rd_valid_d = rd_en;
        rd_zero_d  = rd_zero_q;
        if (rd_en) begin
            rd_zero_d = ({1'b0, rd_addr} >= count_q);
        end

        cap   = (state_q == S_ARMED || state_q == S_POST) && sample && !arm;
        hit   = trig_en && (pc == trig_pc);
        hlt   = (istate == HALT_V);
        wdata = {istate == FETCH_V, istate, psw, pc, cyc_q[15:0]};

        // arm wins over everything, including a capture in the same cycle
        if (arm) begin
            state_d  = S_ARMED;
            count_d  = '0;
            wr_ptr_d = '0;
            post_d   = '0;
            trig_d   = 1'b0;
            halt_d   = 1'b0;
        end else if (cap) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != FULL) begin
                count_d = count_q + (AW + 1)'(1);
            end
            if (state_q == S_ARMED && hit) begin
                trig_d = 1'b1;
                if (POST_TRIG == 0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_POST;
                    post_d  = POST_V;
                end
            end else if (state_q == S_POST) begin
                post_d = post_q - AW'(1);
                if (post_q == AW'(1)) begin
                    state_d = S_DONE;
                end
            end
            if (hlt) begin
                halt_d  = 1'b1;
                state_d = S_DONE;
            end
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_POST);
        done_d = (state_d == S_DONE);
        phys   = ((count_q == FULL) ? wr_ptr_q : '0) + rd_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            post_q     <= '0;
            trig_q     <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cyc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            post_q     <= post_d;
            trig_q     <= trig_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cyc_q      <= cyc_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    // Read-first RAM: a read of the slot being overwritten returns the old entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (rd_en) begin
            ram_q <= mem[phys];
        end
    end

    assign rd_data     = rd_zero_q ? '0 : ram_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign triggered   = trig_q;
    assign halted      = halt_q;
    assign count       = count_q;
    assign cycle_count = cyc_q;

endmodule
